// File: rtl/tcm_arb_pkg.sv
// tcm_arb_pkg: shared port IDs, port-ID type and tracker sizing helper for the TCM data-port arbiter.
package tcm_arb_pkg;
  localparam int PORT_CORE = 0;
  localparam int PORT_EXT  = 1;
  typedef logic port_id_t;
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/tcm_arb_idfifo.sv
// tcm_arb_idfifo: in-order FIFO of port IDs for in-flight downstream requests.
module tcm_arb_idfifo
  import tcm_arb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = cnt_w(DEPTH),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  port_id_t      id_i,
  input  logic          pop_i,
  output port_id_t      head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  port_id_t      mem_q [DEPTH];
  always_comb begin
    wr_d  = push_i ? wr_q + 1'b1 : wr_q;
    rd_d  = pop_i ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= id_i;
  end
  assign head_o  = mem_q[rd_q];
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/tcm_dport_arb.sv
// tcm_dport_arb: round-robin arbiter sharing the TCM data port between two masters, with in-order response routing.
// Define TCM_ARB_FIXED_PRIO_EN to make port 0 always win contention instead of round-robin.
module tcm_dport_arb
  import tcm_arb_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter int TAG_W       = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      m0_addr_i,
  input  logic [31:0]      m0_data_wr_i,
  input  logic             m0_rd_i,
  input  logic [3:0]       m0_wr_i,
  input  logic [TAG_W-1:0] m0_req_tag_i,
  output logic             m0_accept_o,
  output logic             m0_ack_o,
  output logic             m0_error_o,
  output logic [31:0]      m0_data_rd_o,
  output logic [TAG_W-1:0] m0_resp_tag_o,
  input  logic [31:0]      m1_addr_i,
  input  logic [31:0]      m1_data_wr_i,
  input  logic             m1_rd_i,
  input  logic [3:0]       m1_wr_i,
  input  logic [TAG_W-1:0] m1_req_tag_i,
  output logic             m1_accept_o,
  output logic             m1_ack_o,
  output logic             m1_error_o,
  output logic [31:0]      m1_data_rd_o,
  output logic [TAG_W-1:0] m1_resp_tag_o,
  output logic [31:0]      mem_d_addr_o,
  output logic [31:0]      mem_d_data_wr_o,
  output logic             mem_d_rd_o,
  output logic [3:0]       mem_d_wr_o,
  output logic [TAG_W-1:0] mem_d_req_tag_o,
  input  logic             mem_d_accept_i,
  input  logic             mem_d_ack_i,
  input  logic             mem_d_error_i,
  input  logic [31:0]      mem_d_data_rd_i,
  input  logic [TAG_W-1:0] mem_d_resp_tag_i,
  output logic             busy_o,
  output logic             spurious_ack_o
);
  localparam int CW = cnt_w(OUTSTANDING);
  localparam port_id_t CORE = port_id_t'(PORT_CORE);
  localparam port_id_t EXT  = port_id_t'(PORT_EXT);
  logic          req0, req1, gnt_vld, issue, acc, full, empty, rsp;
  port_id_t      gnt, prio, head;
  logic [CW-1:0] count;
  logic          rr_q, rr_d, lock_q, lock_d, spur_q, spur_d;
  port_id_t      lock_id_q, lock_id_d;
  assign req0 = m0_rd_i | (|m0_wr_i);
  assign req1 = m1_rd_i | (|m1_wr_i);
`ifdef TCM_ARB_FIXED_PRIO_EN
  assign prio = CORE;
`else
  assign prio = rr_q;
`endif
  // A stalled grant stays locked so the presented request cannot be swapped under the memory.
  always_comb begin
    gnt       = lock_q ? lock_id_q : (req0 & req1) ? prio : (req1 ? EXT : CORE);
    gnt_vld   = lock_q ? (lock_id_q == EXT ? req1 : req0) : (req0 | req1);
    issue     = gnt_vld & ~full;
    acc       = issue & mem_d_accept_i;
    rr_d      = acc ? ~gnt : rr_q;
    lock_d    = gnt_vld & ~acc;
    lock_id_d = gnt;
    spur_d    = spur_q | (mem_d_ack_i & empty);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q      <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= CORE;
      spur_q    <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      spur_q    <= spur_d;
    end
  end
  assign mem_d_addr_o    = !gnt_vld ? '0 : gnt == EXT ? m1_addr_i : m0_addr_i;
  assign mem_d_data_wr_o = !gnt_vld ? '0 : gnt == EXT ? m1_data_wr_i : m0_data_wr_i;
  assign mem_d_req_tag_o = !gnt_vld ? '0 : gnt == EXT ? m1_req_tag_i : m0_req_tag_i;
  assign mem_d_rd_o      = issue & (gnt == EXT ? m1_rd_i : m0_rd_i);
  assign mem_d_wr_o      = !issue ? 4'b0 : gnt == EXT ? m1_wr_i : m0_wr_i;
  assign m0_accept_o     = acc & (gnt == CORE);
  assign m1_accept_o     = acc & (gnt == EXT);
  // Acks with an empty tracker have no owner and are dropped.
  assign rsp           = mem_d_ack_i & ~empty;
  assign m0_ack_o      = rsp & (head == CORE);
  assign m1_ack_o      = rsp & (head == EXT);
  assign m0_error_o    = m0_ack_o & mem_d_error_i;
  assign m1_error_o    = m1_ack_o & mem_d_error_i;
  assign m0_data_rd_o  = mem_d_data_rd_i;
  assign m1_data_rd_o  = mem_d_data_rd_i;
  assign m0_resp_tag_o = mem_d_resp_tag_i;
  assign m1_resp_tag_o = mem_d_resp_tag_i;
  assign busy_o         = |count;
  assign spurious_ack_o = spur_q;
  tcm_arb_idfifo #(.DEPTH(OUTSTANDING)) u_idfifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (acc),
    .id_i    (gnt),
    .pop_i   (rsp),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
endmodule

// File: tb/tb_tcm_dport_arb.sv
// tb_tcm_dport_arb: directed plus randomized bench against a transaction-level model of the arbiter.
module tb_tcm_dport_arb;
  localparam int OUT = 4;
  localparam int TW  = 11;
`ifdef TCM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  typedef struct {
    int            p;
    logic [TW-1:0] tag;
    logic [31:0]   rdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0][31:0]   addr, wdat, m_rdat;
  logic [1:0]         rd, m_acc, m_ack, m_err;
  logic [1:0][3:0]    wr;
  logic [1:0][TW-1:0] tag, m_rtag;
  logic               d_accept, d_ack, d_err, d_rd_o, busy, spur;
  logic [31:0]        d_rdata, d_addr_o, d_wdat_o;
  logic [TW-1:0]      d_rtag, d_tag_o;
  logic [3:0]         d_wr_o;

  int n_chk = 0;
  int n_fail = 0;
  txn_t q[$];
  int last, lock;
  bit spur_m;
  bit [31:0] mem [bit [31:0]];

  tcm_dport_arb #(.OUTSTANDING(OUT), .TAG_W(TW)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_addr_i(addr[0]), .m0_data_wr_i(wdat[0]), .m0_rd_i(rd[0]), .m0_wr_i(wr[0]), .m0_req_tag_i(tag[0]),
    .m0_accept_o(m_acc[0]), .m0_ack_o(m_ack[0]), .m0_error_o(m_err[0]), .m0_data_rd_o(m_rdat[0]), .m0_resp_tag_o(m_rtag[0]),
    .m1_addr_i(addr[1]), .m1_data_wr_i(wdat[1]), .m1_rd_i(rd[1]), .m1_wr_i(wr[1]), .m1_req_tag_i(tag[1]),
    .m1_accept_o(m_acc[1]), .m1_ack_o(m_ack[1]), .m1_error_o(m_err[1]), .m1_data_rd_o(m_rdat[1]), .m1_resp_tag_o(m_rtag[1]),
    .mem_d_addr_o(d_addr_o), .mem_d_data_wr_o(d_wdat_o), .mem_d_rd_o(d_rd_o), .mem_d_wr_o(d_wr_o), .mem_d_req_tag_o(d_tag_o),
    .mem_d_accept_i(d_accept), .mem_d_ack_i(d_ack), .mem_d_error_i(d_err), .mem_d_data_rd_i(d_rdata), .mem_d_resp_tag_i(d_rtag),
    .busy_o(busy), .spurious_ack_o(spur)
  );

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  function automatic bit [31:0] rd_mem(input bit [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5a5a_0f0f);
  endfunction

  function automatic bit idle(input int p);
    return !rd[p] && wr[p] == 4'h0;
  endfunction

  task automatic issue(input int p, input bit r, input bit [3:0] w, input bit [31:0] a);
    rd[p] = r; wr[p] = w; addr[p] = a; wdat[p] = $urandom; tag[p] = TW'($urandom);
  endtask

  task automatic issue_rand(input int p);
    int k;
    k = $urandom_range(0, 2);
    issue(p, k != 1, k == 0 ? 4'h0 : 4'($urandom_range(1, 15)), {24'h800000, 6'($urandom), 2'b00});
  endtask

  // One clock of the reference: arbitration from the rules, tracker as a transaction queue.
  task automatic step(input bit ack, input bit err = 1'b0);
    int g, ep;
    bit gv, full, acc, ea;
    bit [1:0] r;
    bit [31:0] w;
    txn_t t;
    d_ack = ack; d_err = err;
    d_rdata = q.size() != 0 ? q[0].rdata : $urandom;
    d_rtag  = q.size() != 0 ? q[0].tag : TW'($urandom);
    #1;
    r = {rd[1] || wr[1] != 0, rd[0] || wr[0] != 0};
    full = q.size() == OUT;
    if (lock >= 0) begin g = lock; gv = r[lock]; end
    else if (r == 2'b11) begin g = FIXED ? 0 : 1 - last; gv = 1; end
    else begin g = r == 2'b10 ? 1 : 0; gv = r != 0; end
    acc = gv && d_accept && !full;
    ea = ack && q.size() != 0;
    ep = ea ? q[0].p : 0;
    chk("m0_accept", m_acc[0], acc && g == 0);
    chk("m1_accept", m_acc[1], acc && g == 1);
    chk("mem_d_rd", d_rd_o, gv && !full && rd[g]);
    chk("mem_d_wr", d_wr_o, (gv && !full) ? wr[g] : 4'h0);
    if (gv) begin
      chk("mem_d_addr", d_addr_o, addr[g]);
      chk("mem_d_data_wr", d_wdat_o, wdat[g]);
      chk("mem_d_req_tag", d_tag_o, tag[g]);
    end
    chk("m0_ack", m_ack[0], ea && ep == 0);
    chk("m1_ack", m_ack[1], ea && ep == 1);
    chk("m0_error", m_err[0], ea && ep == 0 && err);
    chk("m1_error", m_err[1], ea && ep == 1 && err);
    if (ea) begin
      chk("resp_tag", m_rtag[ep], q[0].tag);
      chk("resp_data", m_rdat[ep], q[0].rdata);
    end
    chk("busy", busy, q.size() != 0);
    chk("spurious", spur, spur_m);
    if (ea) t = q.pop_front();
    else if (ack) spur_m = 1;
    if (acc) begin
      t.p = g; t.tag = tag[g]; t.rdata = rd_mem(addr[g]);
      w = rd_mem(addr[g]);
      for (int b = 0; b < 4; b++) if (wr[g][b]) w[8*b +: 8] = wdat[g][8*b +: 8];
      mem[addr[g]] = w;
      q.push_back(t);
      last = g;
    end
    lock = (gv && !acc) ? g : -1;
    @(negedge clk);
    if (acc) begin rd[g] = 1'b0; wr[g] = 4'h0; end
  endtask

  task automatic do_reset();
    d_ack = 0;
    rst = 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_spurious", spur, 0);
    rd = '0; wr = '0;
    #1;
    chk("rst_mem_d_rd", d_rd_o, 0);
    chk("rst_mem_d_addr", d_addr_o, 0);
    chk("rst_accept", m_acc, 0);
    q.delete(); last = 1; lock = -1; spur_m = 0;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rd = '0; wr = '0; addr = '0; wdat = '0; tag = '0;
    d_accept = 1; d_ack = 0; d_err = 0; d_rdata = '0; d_rtag = '0;
    @(negedge clk);
    do_reset();
    // single port 0 read, then its ack
    issue(0, 1, 4'h0, 32'h8000_0000);
    step(0);
    step(1);
    // both ports streaming reads with acks returning
    for (int i = 0; i < 12; i++) begin
      if (idle(0)) issue(0, 1, 4'h0, 32'h8000_0000 + 32'(4 * i));
      if (idle(1)) issue(1, 1, 4'h0, 32'h8000_0100 + 32'(4 * i));
      step(q.size() != 0);
    end
    rd = '0;
    while (q.size() != 0) step(1);
    // stalled downstream locks the grant on port 0
    issue(0, 0, 4'hF, 32'h8000_0040);
    d_accept = 0;
    step(0);
    issue(1, 1, 4'h0, 32'h8000_0044);
    step(0);
    step(0);
    d_accept = 1;
    step(0);
    step(0);
    while (q.size() != 0) step(1);
    // fill the tracker, then free one slot
    for (int i = 0; i < 5; i++) begin
      if (idle(0)) issue(0, 1, 4'h0, 32'h8000_0200 + 32'(4 * i));
      step(0);
    end
    step(1, 1);
    step(0);
    while (q.size() != 0) step(1);
    // spurious ack, then reset mid-burst
    step(1);
    step(0);
    issue(0, 1, 4'h0, 32'h8000_0300);
    issue(1, 1, 4'h0, 32'h8000_0304);
    step(0);
    step(0);
    do_reset();
    step(1);
    step(0);
    do_reset();
    // contention straight after reset
    issue(0, 1, 4'h0, 32'h8000_0400);
    issue(1, 1, 4'h0, 32'h8000_0404);
    step(0);
    step(0);
    while (q.size() != 0) step(1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      d_accept = $urandom_range(0, 3) != 0;
      if (idle(0) && $urandom_range(0, 2) == 0) issue_rand(0);
      if (idle(1) && $urandom_range(0, 2) == 0) issue_rand(1);
      step(q.size() != 0 && $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
    end
    rd = '0; wr = '0;
    while (q.size() != 0) step(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
